// File: rtl/i2c_target_rx.sv
// Write-only I2C target receiver: synchronizes SCL/SDA, detects START/STOP, matches ADDR,
// ACKs accepted bytes and strobes each data byte out. Optional glitch filter: I2C_RX_GLITCH_FILTER_EN.
`timescale 1ns/1ps
`default_nettype none

module i2c_target_rx #(
  parameter logic [6:0] ADDR       = 7'h50,
  parameter int          FILTER_LEN = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       sda_oe,
  output logic [7:0] data,
  output logic       data_valid,
  output logic       start_det,
  output logic       stop_det,
  output logic       busy
);

  if (FILTER_LEN < 2 || FILTER_LEN > 15) begin : g_bad_filter_len
    $error("FILTER_LEN must be in 2..15");
  end

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_DATA,
    ST_DATA_ACK,
    ST_IGNORE
  } state_t;

  // ---------------------------------------------------------------------------
  // Input synchronizers (idle bus level is 1)
  // ---------------------------------------------------------------------------
  logic scl_s1_q, scl_s2_q, sda_s1_q, sda_s2_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      scl_s1_q <= 1'b1;
      scl_s2_q <= 1'b1;
      sda_s1_q <= 1'b1;
      sda_s2_q <= 1'b1;
    end else begin
      scl_s1_q <= scl_in;
      scl_s2_q <= scl_s1_q;
      sda_s1_q <= sda_in;
      sda_s2_q <= sda_s1_q;
    end
  end

  logic scl_f, sda_f;

`ifdef I2C_RX_GLITCH_FILTER_EN
  // A filtered line follows its synchronized input only after FILTER_LEN equal samples.
  localparam logic [3:0] FILT_LAST = 4'(FILTER_LEN - 1);

  logic [3:0] scl_cnt_q, scl_cnt_d, sda_cnt_q, sda_cnt_d;
  logic       scl_flt_q, scl_flt_d, sda_flt_q, sda_flt_d;

  always_comb begin
    scl_cnt_d = 4'd0;
    scl_flt_d = scl_flt_q;
    sda_cnt_d = 4'd0;
    sda_flt_d = sda_flt_q;
    if (scl_s2_q != scl_flt_q) begin
      if (scl_cnt_q == FILT_LAST) begin
        scl_flt_d = scl_s2_q;
      end else begin
        scl_cnt_d = scl_cnt_q + 4'd1;
      end
    end
    if (sda_s2_q != sda_flt_q) begin
      if (sda_cnt_q == FILT_LAST) begin
        sda_flt_d = sda_s2_q;
      end else begin
        sda_cnt_d = sda_cnt_q + 4'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      scl_cnt_q <= 4'd0;
      sda_cnt_q <= 4'd0;
      scl_flt_q <= 1'b1;
      sda_flt_q <= 1'b1;
    end else begin
      scl_cnt_q <= scl_cnt_d;
      sda_cnt_q <= sda_cnt_d;
      scl_flt_q <= scl_flt_d;
      sda_flt_q <= sda_flt_d;
    end
  end

  assign scl_f = scl_flt_q;
  assign sda_f = sda_flt_q;
`else
  assign scl_f = scl_s2_q;
  assign sda_f = sda_s2_q;
`endif

  // ---------------------------------------------------------------------------
  // Edge register and bus condition decode
  // ---------------------------------------------------------------------------
  logic scl_p_q, sda_p_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      scl_p_q <= 1'b1;
      sda_p_q <= 1'b1;
    end else begin
      scl_p_q <= scl_f;
      sda_p_q <= sda_f;
    end
  end

  logic scl_rise, scl_fall, start_cond, stop_cond;

  assign scl_rise   = scl_f & ~scl_p_q;
  assign scl_fall   = ~scl_f & scl_p_q;
  assign start_cond = scl_f & sda_p_q & ~sda_f;
  assign stop_cond  = scl_f & ~sda_p_q & sda_f;

  // ---------------------------------------------------------------------------
  // Protocol FSM
  // ---------------------------------------------------------------------------
  state_t     state_q, state_d;
  logic [3:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] shift_q, shift_d;
  logic [7:0] data_q, data_d;
  logic       sda_oe_q, sda_oe_d;
  logic       data_valid_q, data_valid_d;
  logic       start_det_q, start_det_d;
  logic       stop_det_q, stop_det_d;
  logic [7:0] byte_next;

  assign byte_next = {shift_q[6:0], sda_f};

  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    data_d       = data_q;
    sda_oe_d     = sda_oe_q;
    data_valid_d = 1'b0;
    start_det_d  = 1'b0;
    stop_det_d   = 1'b0;

    // Bus conditions override whatever the bit logic was doing.
    if (stop_cond) begin
      state_d    = ST_IDLE;
      sda_oe_d   = 1'b0;
      bit_cnt_d  = 4'd0;
      shift_d    = 8'h00;
      stop_det_d = 1'b1;
    end else if (start_cond) begin
      state_d     = ST_ADDR;
      sda_oe_d    = 1'b0;
      bit_cnt_d   = 4'd0;
      shift_d     = 8'h00;
      start_det_d = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          sda_oe_d = 1'b0;
        end
        ST_ADDR: begin
          sda_oe_d = 1'b0;
          if (scl_rise) begin
            shift_d   = byte_next;
            bit_cnt_d = bit_cnt_q + 4'd1;
            if (bit_cnt_q == 4'd7) begin
              if (byte_next[7:1] == ADDR && !byte_next[0]) begin
                state_d = ST_ADDR_ACK;
              end else begin
                state_d = ST_IGNORE;
              end
            end
          end
        end
        ST_ADDR_ACK: begin
          // First falling edge starts the ACK, the next one ends it.
          if (scl_fall) begin
            if (!sda_oe_q) begin
              sda_oe_d = 1'b1;
            end else begin
              sda_oe_d  = 1'b0;
              bit_cnt_d = 4'd0;
              state_d   = ST_DATA;
            end
          end
        end
        ST_DATA: begin
          sda_oe_d = 1'b0;
          if (scl_rise && bit_cnt_q < 4'd8) begin
            shift_d   = byte_next;
            bit_cnt_d = bit_cnt_q + 4'd1;
          end else if (scl_fall && bit_cnt_q == 4'd8) begin
            data_d       = shift_q;
            data_valid_d = 1'b1;
            sda_oe_d     = 1'b1;
            state_d      = ST_DATA_ACK;
          end
        end
        ST_DATA_ACK: begin
          if (scl_fall) begin
            sda_oe_d  = 1'b0;
            bit_cnt_d = 4'd0;
            state_d   = ST_DATA;
          end
        end
        ST_IGNORE: begin
          sda_oe_d = 1'b0;
        end
        default: begin
          state_d  = ST_IDLE;
          sda_oe_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      bit_cnt_q    <= 4'd0;
      shift_q      <= 8'h00;
      data_q       <= 8'h00;
      sda_oe_q     <= 1'b0;
      data_valid_q <= 1'b0;
      start_det_q  <= 1'b0;
      stop_det_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      data_q       <= data_d;
      sda_oe_q     <= sda_oe_d;
      data_valid_q <= data_valid_d;
      start_det_q  <= start_det_d;
      stop_det_q   <= stop_det_d;
    end
  end

  assign sda_oe     = sda_oe_q;
  assign data       = data_q;
  assign data_valid = data_valid_q;
  assign start_det  = start_det_q;
  assign stop_det   = stop_det_q;
  assign busy       = (state_q != ST_IDLE);

endmodule

`default_nettype wire
